imem_responder: RTL

Responder end of the core's instruction fetch interface. Accepts word-aligned fetch addresses from the fetch stage and returns the instruction word the following cycle. Backing-memory latency is hidden behind a stall signal the core uses to drop its fetch enable. Sits between the fetch stage and a req/gnt/rvalid instruction memory port, with an optional line buffer.

---
 rtl/imem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction fetch responder: serves word fetches from a req/gnt/rvalid memory port.
// Define IMEM_LINE_BUFFER_EN to add a one-line buffer of LINE_WORDS words.
module imem_responder #(
  parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0001_0000,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_enable_i,
  input  logic [31:0] instruction_address_i,
  output logic [31:0] instruction_data_o,
  output logic        stall_o,
  output logic        access_fault_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [31:0] fetch_addr;
  logic [32:0] region_off;
  logic        in_range;

  assign fetch_addr = {instruction_address_i[31:2], 2'b00};
  // Borrow out of the 33-bit subtraction flags addresses below MEM_BASE.
  assign region_off = {1'b0, fetch_addr} - {1'b0, MEM_BASE};
  assign in_range   = !region_off[32] && (region_off[31:0] < MEM_SIZE);

`ifdef IMEM_LINE_BUFFER_EN
  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 30 - OFF_W;

  logic [31:0]      line_mem [LINE_WORDS];
  logic [TAG_W-1:0] tag;
  logic             valid;
  logic             flush_pend;
  logic [OFF_W-1:0] word_cnt;
  logic [OFF_W-1:0] req_off;
  logic             hit;
  logic [31:0]      final_word;
  logic             unused;

  assign hit        = valid && !flush_i && (tag == fetch_addr[31:OFF_W+2]);
  // The requested word may be the one arriving with the final rvalid.
  assign final_word = (req_off == word_cnt) ? mem_rdata_i : line_mem[req_off];
  assign unused     = ^instruction_address_i[1:0];
`else
  logic unused;
  assign unused = ^{flush_i, instruction_address_i[1:0], LINE_WORDS[0]};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= IDLE;
      instruction_data_o <= NOP;
      stall_o            <= 1'b0;
      access_fault_o     <= 1'b0;
      mem_req_o          <= 1'b0;
      mem_addr_o         <= '0;
`ifdef IMEM_LINE_BUFFER_EN
      valid              <= 1'b0;
      flush_pend         <= 1'b0;
      tag                <= '0;
      word_cnt           <= '0;
      req_off            <= '0;
`endif
    end else begin
      access_fault_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_enable_i) begin
            if (!in_range) begin
              instruction_data_o <= NOP;
              access_fault_o     <= 1'b1;
            end
`ifdef IMEM_LINE_BUFFER_EN
            else if (hit) begin
              instruction_data_o <= line_mem[fetch_addr[OFF_W+1:2]];
            end else begin
              tag        <= fetch_addr[31:OFF_W+2];
              req_off    <= fetch_addr[OFF_W+1:2];
              word_cnt   <= '0;
              valid      <= 1'b0;
              flush_pend <= 1'b0;
              mem_addr_o <= {fetch_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
              mem_req_o  <= 1'b1;
              stall_o    <= 1'b1;
              state      <= REQ;
            end
`else
            else begin
              mem_addr_o <= fetch_addr;
              mem_req_o  <= 1'b1;
              stall_o    <= 1'b1;
              state      <= REQ;
            end
`endif
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
`ifdef IMEM_LINE_BUFFER_EN
            line_mem[word_cnt] <= mem_rdata_i;
            if (&word_cnt) begin
              valid              <= !flush_pend;
              instruction_data_o <= final_word;
              stall_o            <= 1'b0;
              state              <= IDLE;
            end else begin
              word_cnt   <= word_cnt + 1'b1;
              mem_addr_o <= mem_addr_o + 32'd4;
              mem_req_o  <= 1'b1;
              state      <= REQ;
            end
`else
            instruction_data_o <= mem_rdata_i;
            stall_o            <= 1'b0;
            state              <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
`ifdef IMEM_LINE_BUFFER_EN
      // Flush overrides any valid update above; a flush mid-refill keeps the line invalid.
      if (flush_i) begin
        valid <= 1'b0;
        if (state != IDLE) flush_pend <= 1'b1;
      end
`endif
    end
  end

endmodule
